alu_ctrl_fsm: RTL and testbench
===============================

// Module: alu_ctrl_fsm
// PURPOSE
//   Control end of the ALU interface: accepts 16-bit instructions over a valid/ready handshake,
//   decodes them and drives the ALU opcode plus register-file read/write addresses, and captures
//   the ALU flags into a status register. Branch instructions test the latched flags and pulse
//   a PC load. Sits between instruction fetch and the datapath (register file + ALU).
// PARAMETERS
//   RAW    3   register-file address width; fixes the rd/ra/rb field widths
//   CNT_W  16  width of the retired-instruction counter
// PORTS
//   clk          in   1      clock; everything is synchronous to its rising edge
//   rst          in   1      synchronous, active-high reset
//   instr_i      in   16     instruction word
//   instr_valid  in   1      instr_i is valid
//   instr_ready  out  1      block can accept an instruction this cycle
//   alu_opcode   out  3      ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 INC, 110 MOVA, 111 MOVB
//   alu_flags    in   3      combinational ALU flags {Z,N,V}; [2]=zero, [1]=negative, [0]=overflow
//   rf_ra        out  RAW    register-file read address, port A
//   rf_rb        out  RAW    register-file read address, port B
//   rf_wa        out  RAW    register-file write address
//   rf_we        out  1      register-file write enable (ALU result is written)
//   pc_load      out  1      one-cycle pulse: fetch must add pc_offset to the PC
//   pc_offset    out  12     signed branch offset
//   status       out  3      latched flags {Z,N,V}
//   halted       out  1      high after HALT until reset
//   retired      out  CNT_W  saturating count of completed instructions
// BEHAVIOUR
//   Encoding: [15]=0 ALU: op=[14:12], rd=[11:9], ra=[8:6], rb=[5:3], [2:0] ignored.
//     [15:14]=10 BR: cond=[13:12] (00 always, 01 Z, 10 N, 11 V), off=[11:0].
//     [15:14]=11 HALT, remaining bits ignored.
//   States: IDLE, EXEC, BRANCH, HALTED. Reset -> IDLE, ir=0, status=000, retired=0.
//   IDLE: instr_ready=1. On instr_valid, latch instr_i into ir, then go to EXEC (ALU),
//     BRANCH (BR) or HALTED (HALT). Without instr_valid, stay in IDLE.
//   EXEC (1 cycle): alu_opcode/rf_ra/rf_rb/rf_wa decoded from ir; rf_we=1; at cycle end
//     status<=alu_flags, retired++, -> IDLE. Every ALU opcode updates status, including MOVA/MOVB.
//   BRANCH (1 cycle): pc_offset=ir[11:0]; pc_load=1 iff cond is met against status (not alu_flags);
//     retired++ whether or not the branch is taken; -> IDLE. status is unchanged.
//   HALTED: instr_ready=0, halted=1. retired is incremented once on entry. Only rst exits.
//   Outside EXEC and BRANCH: rf_we=0, pc_load=0, alu_opcode=000, rf_*=0, pc_offset=0.
//   instr_ready=0 in EXEC, BRANCH and HALTED, so instr_valid in those states is ignored.
//   Throughput: at most 1 instruction every 2 cycles.
//   Reset: rf_we, pc_load and instr_ready are gated combinationally by !rst. A reset cycle
//     therefore has no side effects; reset during EXEC does not write and does not update status.
//   retired saturates at all-ones and does not wrap.
//   Back-to-back: a BR that directly follows an ALU op sees that op's flags, because status is
//     already updated when BRANCH is entered.
// STRUCTURE
//   ctrl_pkg: state_e enum, instr class constants, cond_e codes, field bit positions,
//     flag indices (FLAG_Z=2, FLAG_N=1, FLAG_V=0), ALU opcode localparams.
//   Sub-module branch_cond: combinational (cond, status) -> take. All other logic is inline.
// TESTING
//   1. rst for 2 cycles -> instr_ready=1, status=000, retired=0, halted=0; all strobes low.
//   2. ALU ADD rd=3 ra=1 rb=2 (0x0650), alu_flags=001 -> one cycle later: rf_we=1, rf_wa=3,
//      rf_ra=1, rf_rb=2, alu_opcode=000; then status=001, retired=1.
//   3. Issue SUB with alu_flags=100, then BR Z off=0xFF0 (0x9FF0) -> pc_load=1 for exactly
//      1 cycle, pc_offset=0xFF0. Repeat with status=000 -> pc_load=0, retired still increments.
//   4. instr_valid held high continuously with ADDs -> accepted every 2nd cycle;
//      instr_ready=0 in every EXEC cycle.
//   5. HALT (0xC000) -> halted=1 and instr_ready=0 until rst; further instr_valid is ignored;
//      retired increments once.
//   6. Assert rst during EXEC of an XOR -> rf_we=0 in that cycle, status stays 000, next state IDLE.
//      Force retired to all-ones, then issue an ADD -> retired stays all-ones.

Source files
------------

// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared types and encoding constants for the ALU control FSM.
// Field positions assume the 3-bit register address fields of the 16-bit instruction word.
package alu_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StBranch,
    StHalted
  } state_e;

  typedef enum logic [1:0] {
    ClassAlu,
    ClassBr,
    ClassHalt
  } instr_class_e;

  typedef enum logic [1:0] {
    CondAlways = 2'b00,
    CondZ      = 2'b01,
    CondN      = 2'b10,
    CondV      = 2'b11
  } cond_e;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t AluAdd  = 3'b000;
  localparam alu_op_t AluSub  = 3'b001;
  localparam alu_op_t AluAnd  = 3'b010;
  localparam alu_op_t AluOr   = 3'b011;
  localparam alu_op_t AluXor  = 3'b100;
  localparam alu_op_t AluInc  = 3'b101;
  localparam alu_op_t AluMova = 3'b110;
  localparam alu_op_t AluMovb = 3'b111;

  localparam int unsigned InstrW  = 16;
  localparam int unsigned OffW    = 12;
  localparam int unsigned FlagW   = 3;
  localparam int unsigned ClassB  = 15;
  localparam int unsigned SubB    = 14;
  localparam int unsigned OpMsb   = 14;
  localparam int unsigned CondMsb = 13;
  localparam int unsigned RdMsb   = 11;
  localparam int unsigned RaMsb   = 8;
  localparam int unsigned RbMsb   = 5;

  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagV = 0;

  function automatic instr_class_e instr_class(logic [InstrW-1:0] instr);
    if (!instr[ClassB]) begin
      return ClassAlu;
    end else if (!instr[SubB]) begin
      return ClassBr;
    end
    return ClassHalt;
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Instruction handshake plus datapath control/flag bus between fetch, controller and ALU.
interface alu_ctrl_fsm_if #(
  parameter int unsigned RAW = 3
);
  logic [15:0]    instr_i;
  logic           instr_valid;
  logic           instr_ready;
  logic [2:0]     alu_opcode;
  logic [2:0]     alu_flags;
  logic [RAW-1:0] rf_ra;
  logic [RAW-1:0] rf_rb;
  logic [RAW-1:0] rf_wa;
  logic           rf_we;
  logic           pc_load;
  logic [11:0]    pc_offset;

  // Environment side: fetch supplies instructions, ALU supplies flags.
  modport master (
    output instr_i, instr_valid, alu_flags,
    input  instr_ready, alu_opcode, rf_ra, rf_rb, rf_wa, rf_we, pc_load, pc_offset
  );

  // Controller side.
  modport slave (
    input  instr_i, instr_valid, alu_flags,
    output instr_ready, alu_opcode, rf_ra, rf_rb, rf_wa, rf_we, pc_load, pc_offset
  );
endinterface

// File: rtl/alu_ctrl_fsm_branch_cond.sv
// Branch condition evaluation against the latched {Z,N,V} status.
module alu_ctrl_fsm_branch_cond
  import alu_ctrl_fsm_pkg::*;
(
  input  cond_e            cond_i,
  input  logic [FlagW-1:0] status_i,
  output logic             take_o
);

  always_comb begin
    take_o = 1'b0;
    unique case (cond_i)
      CondAlways: take_o = 1'b1;
      CondZ:      take_o = status_i[FlagZ];
      CondN:      take_o = status_i[FlagN];
      CondV:      take_o = status_i[FlagV];
      default:    take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// ALU control FSM: accepts instructions, drives ALU opcode and register-file addresses,
// latches ALU flags, evaluates branches and counts retired instructions.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned RAW   = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_ctrl_fsm_if.slave     bus,
  output logic [FlagW-1:0]  status,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e             state_q, state_d;
  logic [InstrW-1:0]  ir_q, ir_d;
  logic [FlagW-1:0]   status_q, status_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CNT_W-1:0]   retired_inc;
  logic               take;
  logic               unused_ir;

  // Class bit and don't-care ALU bits are never looked at after decode.
  assign unused_ir = ir_q[ClassB] ^ (^ir_q[2:0]);

  assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

  alu_ctrl_fsm_branch_cond u_branch_cond (
    .cond_i   (cond_e'(ir_q[CondMsb -: 2])),
    .status_i (status_q),
    .take_o   (take)
  );

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    status_d      = status_q;
    retired_d     = retired_q;
    bus.instr_ready = 1'b0;
    bus.alu_opcode  = AluAdd;
    bus.rf_ra       = '0;
    bus.rf_rb       = '0;
    bus.rf_wa       = '0;
    bus.rf_we       = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_offset   = '0;

    unique case (state_q)
      StIdle: begin
        bus.instr_ready = ~rst;
        if (bus.instr_valid) begin
          ir_d = bus.instr_i;
          unique case (instr_class(bus.instr_i))
            ClassAlu: state_d = StExec;
            ClassBr:  state_d = StBranch;
            default: begin
              state_d   = StHalted;
              retired_d = retired_inc;
            end
          endcase
        end
      end
      StExec: begin
        bus.alu_opcode = ir_q[OpMsb -: 3];
        bus.rf_wa      = ir_q[RdMsb -: RAW];
        bus.rf_ra      = ir_q[RaMsb -: RAW];
        bus.rf_rb      = ir_q[RbMsb -: RAW];
        bus.rf_we      = ~rst;
        status_d       = bus.alu_flags;
        retired_d      = retired_inc;
        state_d        = StIdle;
      end
      StBranch: begin
        bus.pc_offset = ir_q[OffW-1:0];
        bus.pc_load   = take & ~rst;
        retired_d     = retired_inc;
        state_d       = StIdle;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      status_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  assign status  = status_q;
  assign halted  = (state_q == StHalted);
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed scoreboard bench for alu_ctrl_fsm; a 2-bit-counter twin checks retired saturation.
module tb_alu_ctrl_fsm;

  logic clk;
  logic rst;

  logic [2:0]  status,  status_s;
  logic        halted,  halted_s;
  logic [15:0] retired;
  logic [1:0]  retired_s;

  alu_ctrl_fsm_if #(.RAW(3)) bus ();
  alu_ctrl_fsm_if #(.RAW(3)) bus_s ();

  alu_ctrl_fsm #(.RAW(3), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .status  (status),
    .halted  (halted),
    .retired (retired)
  );

  alu_ctrl_fsm #(.RAW(3), .CNT_W(2)) dut_s (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_s),
    .status  (status_s),
    .halted  (halted_s),
    .retired (retired_s)
  );

  assign bus_s.instr_i     = bus.instr_i;
  assign bus_s.instr_valid = bus.instr_valid;
  assign bus_s.alu_flags   = bus.alu_flags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_halt;
    logic        rf_we;
    logic [2:0]  op;
    logic [2:0]  wa;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        pc_load;
    logic [11:0] off;
    logic [2:0]  status;
    logic [15:0] retired;
    logic [1:0]  retired_s;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [2:0]  status_m = 3'b000;
  int          ret_m    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: decodes independently and advances the bench's status/retired state.
  function automatic exp_t model(input logic [15:0] ins, input logic [2:0] flags);
    exp_t e;
    logic take;
    e = '0;
    if (!ins[15]) begin
      e.rf_we  = 1'b1;
      e.op     = ins[14:12];
      e.wa     = ins[11:9];
      e.ra     = ins[8:6];
      e.rb     = ins[5:3];
      status_m = flags;
    end else if (!ins[14]) begin
      case (ins[13:12])
        2'b00:   take = 1'b1;
        2'b01:   take = status_m[2];
        2'b10:   take = status_m[1];
        default: take = status_m[0];
      endcase
      e.pc_load = take;
      e.off     = ins[11:0];
    end else begin
      e.is_halt = 1'b1;
    end
    ret_m++;
    e.status    = status_m;
    e.retired   = (ret_m > 65535) ? 16'hFFFF : 16'(ret_m);
    e.retired_s = (ret_m > 3) ? 2'd3 : 2'(ret_m);
    return e;
  endfunction

  // Called just after a rising edge while the DUT is in IDLE.
  task automatic issue(input logic [15:0] ins, input logic [2:0] flags);
    exp_t e;
    sb_q.push_back(model(ins, flags));
    bus.instr_i     = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    check("ready_idle", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr_i     = 16'h0000;
    bus.alu_flags   = flags;
    e = sb_q.pop_front();
    @(negedge clk);
    if (e.is_halt) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_ready", 32'(bus.instr_ready), 32'd0);
      check("halt_retired", 32'(retired), 32'(e.retired));
      check("halt_retired_sat", 32'(retired_s), 32'(e.retired_s));
    end else begin
      check("busy_ready", 32'(bus.instr_ready), 32'd0);
      check("rf_we", 32'(bus.rf_we), 32'(e.rf_we));
      check("opcode", 32'(bus.alu_opcode), 32'(e.op));
      check("rf_wa", 32'(bus.rf_wa), 32'(e.wa));
      check("rf_ra", 32'(bus.rf_ra), 32'(e.ra));
      check("rf_rb", 32'(bus.rf_rb), 32'(e.rb));
      check("pc_load", 32'(bus.pc_load), 32'(e.pc_load));
      check("pc_offset", 32'(bus.pc_offset), 32'(e.off));
      @(posedge clk);
      #1;
      check("status", 32'(status), 32'(e.status));
      check("retired", 32'(retired), 32'(e.retired));
      check("retired_sat", 32'(retired_s), 32'(e.retired_s));
      check("pc_load_after", 32'(bus.pc_load), 32'd0);
      check("rf_we_after", 32'(bus.rf_we), 32'd0);
      check("ready_back", 32'(bus.instr_ready), 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    rst             = 1'b1;
    bus.instr_i     = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.alu_flags   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_status", 32'(status), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_strobes", {29'd0, bus.rf_we, bus.pc_load, |bus.pc_offset}, 32'd0);
    @(posedge clk);
    #1;

    issue(16'h0650, 3'b001);  // ADD r3 = r1 + r2
    issue(16'h1298, 3'b100);  // SUB sets Z
    issue(16'h9FF0, 3'b000);  // BR Z taken; live flags disagree with status
    issue(16'h7400, 3'b000);  // MOVB clears status
    issue(16'h9FF0, 3'b100);  // BR Z not taken
    issue(16'h8123, 3'b000);  // BR always

    // Valid held high: one acceptance every second cycle.
    bus.instr_i     = 16'h0FC8;
    bus.instr_valid = 1'b1;
    bus.alu_flags   = 3'b010;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(model(16'h0FC8, 3'b010));
      @(negedge clk);
      check("stream_ready_idle", 32'(bus.instr_ready), 32'd1);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      @(negedge clk);
      check("stream_ready_exec", 32'(bus.instr_ready), 32'd0);
      check("stream_we", 32'(bus.rf_we), 32'(e.rf_we));
      check("stream_wa", 32'(bus.rf_wa), 32'(e.wa));
      @(posedge clk);
      #1;
      check("stream_retired", 32'(retired), 32'(e.retired));
    end
    bus.instr_valid = 1'b0;
    check("stream_status", 32'(status), 32'(status_m));

    issue(16'hC000, 3'b000);  // HALT
    bus.instr_i     = 16'h0650;
    bus.instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("halted_hold", 32'(halted), 32'd1);
      check("halted_ready", 32'(bus.instr_ready), 32'd0);
      check("halted_we", 32'(bus.rf_we), 32'd0);
      check("halted_retired", 32'(retired), 32'(ret_m));
    end
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    status_m = 3'b000;
    ret_m    = 0;
    @(negedge clk);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_retired", 32'(retired), 32'd0);
    check("unhalt_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset lands in the EXEC cycle of an XOR: no write, no status update.
    bus.instr_i     = 16'h4BB8;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.alu_flags   = 3'b111;
    rst             = 1'b1;
    @(negedge clk);
    check("rst_exec_we", 32'(bus.rf_we), 32'd0);
    check("rst_exec_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_exec_status", 32'(status), 32'd0);
    check("rst_exec_idle", 32'(bus.instr_ready), 32'd1);
    check("rst_exec_retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;

    issue(16'h4BB8, 3'b110);  // XOR resumes normally

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
